// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
//   Shared types and elaboration-time helpers for the multi-player BCD score
//   counter.
//   - bcd_digit_t  : one BCD digit (4 bits)
//   - MAX_DIGITS   : widest supported score, in digits
//   - max_score()  : largest score representable in a given number of digits
//   - int_to_bcd() : converts a decimal constant to packed BCD (ones first)
//   - digit_index(): bit offset of a player's digit in the packed output bus
// -----------------------------------------------------------------------------
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAX_DIGITS = 4;

    // 10^num_digits - 1, e.g. 99 for two digits.
    function automatic int max_score(input int num_digits);
        int v;
        v = 1;
        for (int i = 0; i < num_digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    // Packed BCD of a non-negative integer; digit 0 (ones) in bits [3:0].
    function automatic logic [MAX_DIGITS*4-1:0] int_to_bcd(input int value);
        logic [MAX_DIGITS*4-1:0] bcd;
        int v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

    // Bit offset of digit 'digit' of player 'player' in the packed digit bus.
    function automatic int digit_index(input int player, input int num_digits,
                                       input int digit);
        return (player * num_digits + digit) * 4;
    endfunction

endpackage

// File: rtl/bcd_counter_chain.sv
// -----------------------------------------------------------------------------
// bcd_counter_chain
//   One player's ripple-carry BCD score register.
//   Ports:
//     clk         in   system clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     inc         in   increment request for this player
//     clr         in   synchronous clear (wins over everything else)
//     hold        in   freeze score (game over lockout)
//     digits      out  registered packed BCD score, digit 0 = ones
//     changed     out  registered one-cycle pulse: score changed on last edge
//     next_digits out  combinational value the score takes on the next edge
//                      (used by the parent for same-edge win detection)
// -----------------------------------------------------------------------------
module bcd_counter_chain
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SATURATE   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    inc,
    input  logic                    clr,
    input  logic                    hold,
    output logic [NUM_DIGITS*4-1:0] digits,
    output logic                    changed,
    output logic [NUM_DIGITS*4-1:0] next_digits
);

    logic [NUM_DIGITS*4-1:0] digits_q;
    logic                    changed_q;
    logic [NUM_DIGITS*4-1:0] inc_val;
    logic                    at_max;
    logic                    changed_next;
    bcd_digit_t              dig;
    logic                    carry;

    // Ripple +1: each 9 rolls to 0 and passes the carry up. A carry out of
    // the top digit means every digit was 9, i.e. the score is at maximum.
    always_comb begin
        carry   = 1'b1;
        dig     = '0;
        inc_val = digits_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            dig = digits_q[d*4 +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    inc_val[d*4 +: 4] = 4'd0;
                end else begin
                    inc_val[d*4 +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        at_max = carry;
    end

    // Priority: clr > hold > inc. Saturating at max leaves the score alone
    // and therefore produces no point pulse.
    always_comb begin
        next_digits  = digits_q;
        changed_next = 1'b0;
        if (clr) begin
            next_digits = '0;
        end else if (hold) begin
            next_digits = digits_q;
        end else if (inc) begin
            if (at_max && (SATURATE != 0)) begin
                next_digits = digits_q;
            end else begin
                next_digits  = inc_val;
                changed_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            digits_q  <= next_digits;
            changed_q <= changed_next;
        end
    end

    assign digits  = digits_q;
    assign changed = changed_q;

endmodule

// File: rtl/multi_score_counter.sv
// -----------------------------------------------------------------------------
// multi_score_counter
//   Parametrised multi-player BCD score counter with wrap/saturate at maximum,
//   programmable winning score, latched game-over and winner index.
//   Ports:
//     clk       in   system clock, rising edge
//     reset_n   in   asynchronous active-low reset
//     inc       in   per-player increment request
//     clr       in   synchronous clear of all scores and game state
//     digits    out  packed BCD, player p digit d at [(p*NUM_DIGITS+d)*4 +: 4]
//     point     out  one-cycle pulse per player whose score changed
//     game_over out  latched: some player reached WIN_SCORE
//     winner    out  index of winning player while game_over=1, else 0
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module multi_score_counter
    import score_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int NUM_DIGITS  = 2,
    parameter  int WIN_SCORE   = 11,
    parameter  int SATURATE    = 0,
    localparam int WINNER_W    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_PLAYERS-1:0]             inc,
    input  logic                               clr,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] digits,
    output logic [NUM_PLAYERS-1:0]             point,
    output logic                               game_over,
    output logic [WINNER_W-1:0]                winner
);

    generate
        if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
            $error("multi_score_counter: NUM_PLAYERS out of range 1..8");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
            $error("multi_score_counter: NUM_DIGITS out of range 1..4");
        end
        if (WIN_SCORE < 0 || WIN_SCORE > max_score(NUM_DIGITS)) begin : g_bad_win
            $error("multi_score_counter: WIN_SCORE exceeds maximum score");
        end
    endgenerate

    localparam logic [MAX_DIGITS*4-1:0] WIN_BCD_ALL = int_to_bcd(WIN_SCORE);
    localparam logic [NUM_DIGITS*4-1:0] WIN_BCD     = WIN_BCD_ALL[NUM_DIGITS*4-1:0];

    logic                    game_over_q;
    logic [WINNER_W-1:0]     winner_q;
    logic [WINNER_W-1:0]     winner_sel;
    logic [NUM_PLAYERS-1:0]  win_hit;
    logic [NUM_DIGITS*4-1:0] next_score [NUM_PLAYERS];

    genvar p;
    generate
        for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
            localparam int BASE = digit_index(p, NUM_DIGITS, 0);

            bcd_counter_chain #(
                .NUM_DIGITS (NUM_DIGITS),
                .SATURATE   (SATURATE)
            ) u_chain (
                .clk         (clk),
                .reset_n     (reset_n),
                .inc         (inc[p]),
                .clr         (clr),
                .hold        (game_over_q),
                .digits      (digits[BASE +: NUM_DIGITS*4]),
                .changed     (point[p]),
                .next_digits (next_score[p])
            );

            // Compare against the value being loaded this edge so the winning
            // score and game_over appear together.
            assign win_hit[p] = (WIN_SCORE != 0) && inc[p] &&
                                (next_score[p] == WIN_BCD);
        end
    endgenerate

    // Lowest index wins a tie: scan downward so the last match is the lowest.
    always_comb begin
        winner_sel = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                winner_sel = WINNER_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            game_over_q <= 1'b0;
            winner_q    <= '0;
        end else if (clr) begin
            game_over_q <= 1'b0;
            winner_q    <= '0;
        end else if (!game_over_q && (|win_hit)) begin
            game_over_q <= 1'b1;
            winner_q    <= winner_sel;
        end
    end

    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
